dcr_alu_issue: RTL
==================

# dcr_alu_issue

Decode/issue stage that produces the operand and function-code stream consumed by the P3 ALU. It accepts 32-bit MIPS-style instruction words together with their register-file read data, decodes them into the ALU's 4-bit `funct` encoding, builds the `x`/`y` operands (register, shift amount or extended immediate), and holds the result in an output pipeline register. The output register is backed by a one-entry skid buffer under a valid/ready handshake, so the ALU stage can stall without losing instructions.

## Interface

- No parameters; all widths are fixed: 32-bit data, 5-bit register index, 4-bit funct.

Ports, in order:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: synchronous drop of every held entry.
- `in_valid` in 1: instruction presented.
- `in_ready` out 1: block can accept; registered.
- `in_instr` in 32: instruction word.
- `rs_addr` out 5: `in_instr[25:21]`; combinational, drives the register file.
- `rt_addr` out 5: `in_instr[20:16]`; combinational, drives the register file.
- `rs_data` in 32: register-file data for `rs_addr`, same cycle.
- `rt_data` in 32: register-file data for `rt_addr`, same cycle.
- `out_valid` out 1: issued operation valid.
- `out_ready` in 1: ALU stage consumes.
- `out_x` out 32: ALU x operand.
- `out_y` out 32: ALU y operand.
- `out_funct` out 4: ALU function code.
- `out_rd` out 5: destination register.
- `out_wb_en` out 1: result is to be written back.
- `out_illegal` out 1: undecodable instruction.

## Operation

ALU funct codes:
- 0 AND, 1 OR, 2 XOR, 3 NOR
- 4 ADDU, 5 ADD, 6 SUBU, 7 SUB
- A SLTU, B SLT
- C SLL, E SRL, F SRA

For shifts, the ALU computes y shifted by x, so x carries the shift amount and y carries the value.

- **R-type (opcode 0x00):** `rd = instr[15:11]`.
  - Funct 0x24/25/26/27 map to 0/1/2/3.
  - Funct 0x20/21/22/23 map to 5/4/7/6.
  - Funct 0x2A/2B map to B/A.
  - For all of these: x=`rs_data`, y=`rt_data`.
- **Immediate shifts:** SLL 0x00, SRL 0x02, SRA 0x03 map to C/E/F with x=zero-extended `instr[10:6]` and y=`rt_data`.
- **Variable shifts:** SLLV 0x04, SRLV 0x06, SRAV 0x07 map to C/E/F with x=`{27'b0, rs_data[4:0]}` and y=`rt_data`.
- **I-type:** `rd = instr[20:16]`, x=`rs_data`, `imm = instr[15:0]`.
  - ADDI 0x08 maps to 5 and ADDIU 0x09 to 4; both use y=sign-extended imm.
  - SLTI 0x0A maps to B and SLTIU 0x0B to A; both use y=sign-extended imm.
  - ANDI 0x0C, ORI 0x0D, XORI 0x0E map to 0/1/2 with y=zero-extended imm.
  - LUI 0x0F maps to C with x=16 and y=zero-extended imm.
- **`out_wb_en`:** 1 for every legal instruction, including those with rd=0; suppressing writes to register 0 is downstream's job.
- **Illegal instructions:** any other opcode or R-type funct gives `out_illegal`=1, `out_wb_en`=0, funct=0, x=y=0, rd=0. An illegal instruction still occupies a slot and is still issued.
- **Storage:** main output register (M) plus skid register (S), each holding one decoded entry and a valid bit.

## Timing

- **Reset:** `out_valid`=0, S empty, and all out data fields = 0. `in_ready`=0 during the reset cycle and 1 on the first cycle after.
- **Accept:** an instruction is accepted when `in_valid && in_ready`. `rs_data`/`rt_data` are sampled in that same cycle.
- **Latency:** the accepted entry appears on the outputs the next cycle. Throughput is 1 per cycle when `out_ready` is held high.
- **Output consumption:** the output is consumed when `out_valid && out_ready`. Output fields remain stable while `out_valid && !out_ready`.
- **Per-edge update rules:**
  - M empty, or M consumed this cycle: M loads S if S is valid, else the new accept if there is one, else M becomes empty.
  - If S moves to M in the same cycle as an accept, the accept goes to S.
  - M valid, not consumed, accept present: the accept goes to S.
- **`in_ready` (next cycle):** equals !S_valid after the update, so `in_ready` is never combinational from `out_ready`.
- **Flush:** on the next edge, M and S are emptied, `out_valid`=0 and `in_ready`=1. The accept in the flush cycle is discarded. Flush takes priority over every other event except reset; reset dominates flush.
- **Reset mid-stream:** all held entries are lost with no partial output.

## Test plan

- **Basic R-type:** `0x00221821` (ADDU r3,r1,r2) with rs=5, rt=7, `out_ready`=1 -> next cycle: `out_valid`=1, funct=4, x=5, y=7, rd=3, `out_wb_en`=1.
- **Sign-extended immediate:** `0x2022FFFF` (ADDI r2,r1,-1) with rs=10 -> funct=5, x=10, y=0xFFFFFFFF, rd=2. Then `0x3C041234` (LUI r4) -> funct=C, x=16, y=0x00001234, rd=4.
- **Shifts:** `0x00031083` (SRA r2,r3,2) with rt=0x80000000 -> funct=F, x=2, y=0x80000000. SRLV with rs=0x25 -> x=5.
- **Backpressure:** three back-to-back accepts, `out_ready`=0 from cycle 1. Entries A and B are accepted and `in_ready` falls after B; C is held off. With `out_ready`=1, the outputs are A, B, C in order with none lost or duplicated.
- **Illegal and flush:** opcode 0x3F -> `out_illegal`=1, `out_wb_en`=0, funct=0, x=y=0. With M and S full, `flush`=1 -> next cycle `out_valid`=0, `in_ready`=1.
- **Reset:** reset asserted with entries held -> outputs zero and `out_valid`=0; `in_ready`=1 the cycle after reset drops.

Source files
------------

// File: rtl/dcr_alu_issue.sv
// Decode/issue stage feeding the ALU: MIPS word -> funct/x/y/rd, one-cycle latency.
// Output register backed by a one-entry skid; in_ready is !skid_valid, never combinational from out_ready.
module dcr_alu_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_x,
  output logic [31:0] out_y,
  output logic [3:0]  out_funct,
  output logic [4:0]  out_rd,
  output logic        out_wb_en,
  output logic        out_illegal
);

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  funct;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;
  } issue_t;

  issue_t dec;
  issue_t m_q, m_d, s_q, s_d;
  logic   m_vld_q, m_vld_d, s_vld_q, s_vld_d;
  logic   legal, accept, m_free;

  logic [5:0]  op, fn;
  logic [31:0] imm_se, imm_ze;

  assign rs_addr = in_instr[25:21];
  assign rt_addr = in_instr[20:16];
  assign op      = in_instr[31:26];
  assign fn      = in_instr[5:0];
  assign imm_se  = {{16{in_instr[15]}}, in_instr[15:0]};
  assign imm_ze  = {16'h0000, in_instr[15:0]};

  always_comb begin
    dec   = '0;
    legal = 1'b1;
    dec.x = rs_data;
    if (op == 6'h00) begin
      dec.rd = in_instr[15:11];
      dec.y  = rt_data;
      case (fn)
        6'h24: dec.funct = 4'h0;
        6'h25: dec.funct = 4'h1;
        6'h26: dec.funct = 4'h2;
        6'h27: dec.funct = 4'h3;
        6'h20: dec.funct = 4'h5;
        6'h21: dec.funct = 4'h4;
        6'h22: dec.funct = 4'h7;
        6'h23: dec.funct = 4'h6;
        6'h2A: dec.funct = 4'hB;
        6'h2B: dec.funct = 4'hA;
        // Shifts: x is the amount, y the value being shifted.
        6'h00: begin dec.funct = 4'hC; dec.x = {27'b0, in_instr[10:6]}; end
        6'h02: begin dec.funct = 4'hE; dec.x = {27'b0, in_instr[10:6]}; end
        6'h03: begin dec.funct = 4'hF; dec.x = {27'b0, in_instr[10:6]}; end
        6'h04: begin dec.funct = 4'hC; dec.x = {27'b0, rs_data[4:0]}; end
        6'h06: begin dec.funct = 4'hE; dec.x = {27'b0, rs_data[4:0]}; end
        6'h07: begin dec.funct = 4'hF; dec.x = {27'b0, rs_data[4:0]}; end
        default: legal = 1'b0;
      endcase
    end else begin
      dec.rd = in_instr[20:16];
      case (op)
        6'h08: begin dec.funct = 4'h5; dec.y = imm_se; end
        6'h09: begin dec.funct = 4'h4; dec.y = imm_se; end
        6'h0A: begin dec.funct = 4'hB; dec.y = imm_se; end
        6'h0B: begin dec.funct = 4'hA; dec.y = imm_se; end
        6'h0C: begin dec.funct = 4'h0; dec.y = imm_ze; end
        6'h0D: begin dec.funct = 4'h1; dec.y = imm_ze; end
        6'h0E: begin dec.funct = 4'h2; dec.y = imm_ze; end
        6'h0F: begin dec.funct = 4'hC; dec.x = 32'd16; dec.y = imm_ze; end
        default: legal = 1'b0;
      endcase
    end
    if (legal) begin
      dec.wb_en = 1'b1;
    end else begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  assign in_ready = !s_vld_q && !reset;
  assign accept   = in_valid && in_ready;
  assign m_free   = !m_vld_q || out_ready;

  always_comb begin
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (m_free) begin
      if (s_vld_q) begin
        m_vld_d = 1'b1;
        m_d     = s_q;
        s_vld_d = accept;
        if (accept) s_d = dec;
      end else begin
        m_vld_d = accept;
        if (accept) m_d = dec;
      end
    end else if (accept) begin
      s_vld_d = 1'b1;
      s_d     = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  assign out_valid   = m_vld_q;
  assign out_x       = m_q.x;
  assign out_y       = m_q.y;
  assign out_funct   = m_q.funct;
  assign out_rd      = m_q.rd;
  assign out_wb_en   = m_q.wb_en;
  assign out_illegal = m_q.illegal;

endmodule
